score_keeper: RTL and testbench

//   Match-state and score counter for Pong, directly upstream of the score digit renderer.

---
 rtl/score_keeper.sv | 128 ++++++++++++
 tb/tb_score_keeper.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Pong match sequencer and score counter: idle -> serve -> play -> point -> serve ... -> over.
// All outputs are registered, so an input pulse on edge N shows on the outputs after edge N.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam int              CW        = $clog2(SERVE_FRAMES + 1);
  localparam logic [3:0]      WIN       = 4'(WIN_SCORE);
  localparam logic [CW-1:0]   LAST_TICK = CW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic          r_br;
  logic          r_sd;
  logic          r_go;
  logic          r_win;

  logic [3:0]    w_s1_inc;
  logic [3:0]    w_s2_inc;

  // Saturating increments keep the renderer inside its 0..9 font.
  assign w_s1_inc = (r_s1 >= WIN) ? WIN : r_s1 + 4'd1;
  assign w_s2_inc = (r_s2 >= WIN) ? WIN : r_s2 + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_s1    <= 4'd0;
      r_s2    <= 4'd0;
      r_br    <= 1'b1;
      r_sd    <= 1'b0;
      r_go    <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
            r_cnt   <= '0;
            r_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (r_cnt == LAST_TICK) begin
              r_cnt   <= '0;
              r_br    <= 1'b0;
              r_state <= S_PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          // A simultaneous double goal is a dead rally: re-serve without scoring.
          if (goal_left && goal_right) begin
            r_br    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_SERVE;
          end else if (goal_right) begin
            r_s1  <= w_s1_inc;
            r_sd  <= 1'b1;
            r_br  <= 1'b1;
            r_cnt <= '0;
            if (w_s1_inc == WIN) begin
              r_go    <= 1'b1;
              r_win   <= 1'b0;
              r_state <= S_OVER;
            end else begin
              r_state <= S_SERVE;
            end
          end else if (goal_left) begin
            r_s2  <= w_s2_inc;
            r_sd  <= 1'b0;
            r_br  <= 1'b1;
            r_cnt <= '0;
            if (w_s2_inc == WIN) begin
              r_go    <= 1'b1;
              r_win   <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_state <= S_SERVE;
            end
          end
        end
        S_OVER: begin
          if (start) begin
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
            r_go    <= 1'b0;
            r_sd    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SERVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score1     = r_s1;
  assign score2     = r_s2;
  assign ball_reset = r_br;
  assign serve_dir  = r_sd;
  assign game_over  = r_go;
  assign winner     = r_win;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, hand sequences for match end and async reset,
// then random play checked against a rule-level match model.
module tb_score_keeper;

  localparam int WIN = 9;
  localparam int SF  = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
  logic [3:0] score1, score2;
  logic       ball_reset, serve_dir, game_over, winner;

  int n_cmp = 0;
  int n_bad = 0;

  score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .goal_left(goal_left), .goal_right(goal_right),
    .score1(score1), .score2(score2), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       st, gl, gr, tk;
    logic [3:0] s1, s2;
    logic       br, sd, go, wn;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one input pattern for n consecutive clocks; outputs are settled 1 ns after the edge.
  task automatic cyc(input logic st, gl, gr, tk, input int n);
    for (int i = 0; i < n; i++) begin
      start = st; goal_left = gl; goal_right = gr; frame_tick = tk;
      @(posedge clk);
      #1;
      start = 1'b0; goal_left = 1'b0; goal_right = 1'b0; frame_tick = 1'b0;
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] s1, s2, input logic br, sd, go);
    chk({nm, ".score1"}, 16'(score1), 16'(s1));
    chk({nm, ".score2"}, 16'(score2), 16'(s2));
    chk({nm, ".ball_reset"}, 16'(ball_reset), 16'(br));
    chk({nm, ".serve_dir"}, 16'(serve_dir), 16'(sd));
    chk({nm, ".game_over"}, 16'(game_over), 16'(go));
  endtask

  // Rule-level model: phase plus serve frames still owed before the ball is released.
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_OVER = 3;
  int   m_phase, m_s1, m_s2, m_owed;
  logic m_sd, m_win;

  task automatic model_step(input logic st, gl, gr, tk);
    if (m_phase == P_IDLE) begin
      if (st) begin m_s1 = 0; m_s2 = 0; m_owed = SF; m_phase = P_SERVE; end
    end else if (m_phase == P_SERVE) begin
      if (tk) begin
        m_owed = m_owed - 1;
        if (m_owed == 0) m_phase = P_PLAY;
      end
    end else if (m_phase == P_PLAY) begin
      if (gl && gr) begin
        m_owed = SF; m_phase = P_SERVE;
      end else if (gl || gr) begin
        if (gr) begin m_s1 = (m_s1 < WIN) ? m_s1 + 1 : WIN; m_sd = 1'b1; end
        else    begin m_s2 = (m_s2 < WIN) ? m_s2 + 1 : WIN; m_sd = 1'b0; end
        m_owed = SF;
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_phase = P_OVER;
          m_win = (m_s2 == WIN);
        end else begin
          m_phase = P_SERVE;
        end
      end
    end else begin
      if (st) begin m_s1 = 0; m_s2 = 0; m_sd = 1'b0; m_owed = SF; m_phase = P_SERVE; end
    end
  endtask

  initial begin : main
    logic st, gl, gr, tk;
    logic [10:0] exp_v, act_v;

    //              n     st gl gr tk  s1 s2 br sd go wn
    tbl.push_back('{1,    0, 0, 0, 0,  0, 0, 1, 0, 0, 0});  // idle after reset
    tbl.push_back('{1,    1, 0, 0, 0,  0, 0, 1, 0, 0, 0});  // start -> serve
    tbl.push_back('{SF-1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0});  // one tick short
    tbl.push_back('{1,    0, 0, 0, 1,  0, 0, 0, 0, 0, 0});  // last tick releases ball
    tbl.push_back('{1,    0, 0, 1, 0,  1, 0, 1, 1, 0, 0});  // point to p1
    tbl.push_back('{5,    0, 1, 0, 0,  1, 0, 1, 1, 0, 0});  // goals during serve ignored
    tbl.push_back('{SF-2, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0});
    tbl.push_back('{1,    0, 1, 0, 1,  1, 0, 1, 1, 0, 0});  // tick counts, goal ignored
    tbl.push_back('{1,    0, 0, 0, 1,  1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,    0, 1, 1, 0,  1, 0, 1, 1, 0, 0});  // double goal: no score
    tbl.push_back('{SF,   0, 0, 0, 1,  1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,    1, 1, 0, 1,  1, 1, 1, 0, 0, 0});  // goal beats start and tick
    tbl.push_back('{1,    1, 0, 0, 0,  1, 1, 1, 0, 0, 0});  // start ignored in serve
    tbl.push_back('{SF-1, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0});
    tbl.push_back('{1,    0, 0, 0, 1,  1, 1, 0, 0, 0, 0});
    tbl.push_back('{1,    0, 0, 1, 0,  2, 1, 1, 1, 0, 0});
    tbl.push_back('{1,    0, 0, 1, 0,  2, 1, 1, 1, 0, 0});  // second goal after rally ends
    tbl.push_back('{SF,   0, 0, 0, 1,  2, 1, 0, 1, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("reset.winner", 16'(winner), 16'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].gl, tbl[i].gr, tbl[i].tk, tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].br, tbl[i].sd, tbl[i].go);
      if (tbl[i].go) chk($sformatf("vec%0d.winner", i), 16'(winner), 16'(tbl[i].wn));
    end

    // Player2 runs up to 8, then the winning goal.
    for (int k = 2; k <= WIN - 1; k++) begin
      cyc(0, 1, 0, 0, 1);
      chk_all($sformatf("p2_to_%0d", k), 4'd2, 4'(k), 1'b1, 1'b0, 1'b0);
      cyc(0, 0, 0, 1, SF);
    end
    cyc(0, 1, 0, 0, 1);
    chk_all("p2_wins", 4'd2, 4'd9, 1'b1, 1'b0, 1'b1);
    chk("p2_wins.winner", 16'(winner), 16'd1);
    cyc(0, 1, 0, 0, 2);
    cyc(0, 0, 1, 1, 70);
    chk_all("over_frozen", 4'd2, 4'd9, 1'b1, 1'b0, 1'b1);
    chk("over_frozen.winner", 16'(winner), 16'd1);
    cyc(1, 0, 0, 0, 1);
    chk_all("restart", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 1, SF);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, SF);
    end
    chk_all("p1_at_4_play", 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("async_rst.winner", 16'(winner), 16'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 1, 1, 3);
    chk_all("idle_ignores", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Random play against the model, starting from IDLE.
    m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_owed = 0; m_sd = 1'b0; m_win = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      st = ($urandom_range(0, 39) == 0);
      gl = ($urandom_range(0, 24) == 0);
      gr = ($urandom_range(0, 24) == 0);
      tk = ($urandom_range(0, 1) == 0);
      cyc(st, gl, gr, tk, 1);
      model_step(st, gl, gr, tk);
      exp_v = {4'(m_s1), 4'(m_s2), (m_phase != P_PLAY), m_sd, (m_phase == P_OVER)};
      act_v = {score1, score2, ball_reset, serve_dir, game_over};
      chk($sformatf("rand%0d.{s1,s2,br,sd,go}", c), 16'(act_v), 16'(exp_v));
      if (m_phase == P_OVER) chk($sformatf("rand%0d.winner", c), 16'(winner), 16'(m_win));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
